// File: rtl/udp2srio_segmenter.sv
// udp2srio_segmenter: cuts UDP frames into SRIO NWRITE segments in a circular window.
// Optional frame/segment/error counters: define UDP2SRIO_STATS_EN.
module udp2srio_segmenter #(
    parameter int DATA_W = 64,
    parameter int SEG_BYTES = 256,
    parameter int ADDR_W = 34,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int ADDR_SPAN = 65536,
    localparam int KEEP_W = DATA_W / 8,
    localparam int LW = $clog2(SEG_BYTES),
    localparam int OW = $clog2(ADDR_SPAN)
) (
    input  logic              clk_srio,
    input  logic              reset_srio,
    input  logic [DATA_W-1:0] udp_data_in,
    input  logic              udp_valid_in,
    input  logic              udp_first_in,
    input  logic [KEEP_W-1:0] udp_keep_in,
    input  logic              udp_last_in,
    input  logic [15:0]       udp_length_in,
    output logic              udp_ready_out,
    output logic              nwr_req_out,
    input  logic              nwr_ack_in,
    output logic [ADDR_W-1:0] srio_addr_out,
    output logic [LW-1:0]     srio_length_out,
    output logic [DATA_W-1:0] srio_data_out,
    output logic              srio_valid_out,
    output logic              srio_first_out,
    output logic [KEEP_W-1:0] srio_keep_out,
    output logic              srio_last_out,
    input  logic              srio_ready_in,
    input  logic              err_clr_in,
`ifdef UDP2SRIO_STATS_EN
    output logic [31:0]       stat_frames_out,
    output logic [31:0]       stat_segs_out,
    output logic [15:0]       stat_errs_out,
`endif
    output logic              err_out
);

    typedef enum logic [1:0] {IDLE, REQ, DATA, DRAIN} state_t;

    localparam logic [LW:0]   SEG_MAX = (LW+1)'(SEG_BYTES);
    localparam logic [LW:0]   ONE = (LW+1)'(1);
    localparam logic [LW+1:0] KSTEP = (LW+2)'(KEEP_W);
    localparam logic [LW+1:0] KMASK = (LW+2)'(KEEP_W - 1);

    state_t          state, state_nx;
    logic [16:0]     remain, remain_nx;
    logic [LW:0]     seg_len, seg_len_nx;
    logic [OW-1:0]   offset, offset_nx;
    logic [LW+1:0]   cnt, cnt_nx;
    logic            err_evt;

    logic            acc;
    logic [LW+1:0]   cnt_inc;
    logic            full;
    logic            seg_hit;
    logic            seg_end;
    logic [16:0]     remain_sub;
    logic [LW+1:0]   seg_round;

    function automatic logic [LW:0] seg_of(input logic [16:0] r);
        if (r > 17'(SEG_BYTES)) return SEG_MAX;
        return r[LW:0];
    endfunction

    assign acc        = (state == DATA) && udp_valid_in && srio_ready_in;
    assign cnt_inc    = cnt + KSTEP;
    assign full       = cnt_inc >= (LW+2)'(seg_len);
    assign seg_hit    = full || udp_last_in;
    assign seg_end    = acc && seg_hit;
    assign remain_sub = remain - 17'(seg_len);
    // segments occupy whole beats of address space
    assign seg_round  = ((LW+2)'(seg_len) + KMASK) & ~KMASK;

    always_ff @(posedge clk_srio or posedge reset_srio) begin
        if (reset_srio) begin
            state   <= IDLE;
            remain  <= '0;
            seg_len <= '0;
            offset  <= '0;
            cnt     <= '0;
            err_out <= 1'b0;
        end else begin
            state   <= state_nx;
            remain  <= remain_nx;
            seg_len <= seg_len_nx;
            offset  <= offset_nx;
            cnt     <= cnt_nx;
            err_out <= err_evt | (err_out & ~err_clr_in);
        end
    end

    always_comb begin
        state_nx   = state;
        remain_nx  = remain;
        seg_len_nx = seg_len;
        offset_nx  = offset;
        cnt_nx     = cnt;
        err_evt    = 1'b0;
        unique case (state)
            IDLE: begin
                if (udp_valid_in && udp_first_in) begin
                    remain_nx  = {1'b0, udp_length_in};
                    seg_len_nx = seg_of({1'b0, udp_length_in});
                    cnt_nx     = '0;
                    if (udp_length_in == 16'd0) begin
                        err_evt  = 1'b1;
                        state_nx = DRAIN;
                    end else begin
                        state_nx = REQ;
                    end
                end
            end
            REQ: begin
                if (nwr_ack_in) state_nx = DATA;
            end
            DATA: begin
                if (acc) begin
                    cnt_nx = cnt_inc;
                    if (seg_hit) begin
                        cnt_nx     = '0;
                        remain_nx  = remain_sub;
                        offset_nx  = offset + OW'(seg_round);
                        seg_len_nx = seg_of(remain_sub);
                        if (udp_last_in) begin
                            err_evt  = !full || (remain_sub != 17'd0);
                            state_nx = IDLE;
                        end else if (remain_sub != 17'd0) begin
                            state_nx = REQ;
                        end else begin
                            err_evt  = 1'b1;
                            state_nx = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (udp_valid_in && udp_last_in) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign srio_addr_out = BASE_ADDR + ADDR_W'(offset);

    always_comb begin
        udp_ready_out   = 1'b0;
        nwr_req_out     = 1'b0;
        srio_length_out = '0;
        srio_data_out   = '0;
        srio_keep_out   = '0;
        srio_valid_out  = 1'b0;
        srio_first_out  = 1'b0;
        srio_last_out   = 1'b0;
        unique case (state)
            IDLE: ;
            REQ: begin
                nwr_req_out     = 1'b1;
                srio_length_out = LW'(seg_len - ONE);
            end
            DATA: begin
                udp_ready_out  = srio_ready_in;
                srio_valid_out = udp_valid_in;
                srio_data_out  = udp_data_in;
                srio_keep_out  = udp_keep_in;
                srio_first_out = udp_valid_in && (cnt == '0);
                srio_last_out  = udp_valid_in && seg_hit;
            end
            DRAIN: udp_ready_out = 1'b1;
            default: ;
        endcase
    end

`ifdef UDP2SRIO_STATS_EN
    logic frame_done;

    assign frame_done = (seg_end && udp_last_in) ||
                        ((state == DRAIN) && udp_valid_in && udp_last_in);

    always_ff @(posedge clk_srio or posedge reset_srio) begin
        if (reset_srio) begin
            stat_frames_out <= '0;
            stat_segs_out   <= '0;
            stat_errs_out   <= '0;
        end else begin
            if (frame_done) stat_frames_out <= stat_frames_out + 32'd1;
            if (seg_end) stat_segs_out <= stat_segs_out + 32'd1;
            if (err_evt) stat_errs_out <= stat_errs_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_udp2srio_segmenter.sv
// Scoreboard bench for udp2srio_segmenter: random frames against a segment-level model.
// Stats checks compile in when UDP2SRIO_STATS_EN is defined.
module tb_udp2srio_segmenter;

    localparam int DATA_W = 64;
    localparam int KEEP_W = 8;
    localparam int SEG = 256;
    localparam int AW = 34;
    localparam int SPAN = 1024;
    localparam logic [AW-1:0] BASE = 34'h1_0000_0400;

    logic              clk_srio = 1'b0;
    logic              reset_srio;
    logic [DATA_W-1:0] udp_data_in;
    logic              udp_valid_in;
    logic              udp_first_in;
    logic [KEEP_W-1:0] udp_keep_in;
    logic              udp_last_in;
    logic [15:0]       udp_length_in;
    logic              udp_ready_out;
    logic              nwr_req_out;
    logic              nwr_ack_in;
    logic [AW-1:0]     srio_addr_out;
    logic [7:0]        srio_length_out;
    logic [DATA_W-1:0] srio_data_out;
    logic              srio_valid_out;
    logic              srio_first_out;
    logic [KEEP_W-1:0] srio_keep_out;
    logic              srio_last_out;
    logic              srio_ready_in;
    logic              err_clr_in;
    logic              err_out;
`ifdef UDP2SRIO_STATS_EN
    logic [31:0]       stat_frames_out;
    logic [31:0]       stat_segs_out;
    logic [15:0]       stat_errs_out;
`endif

    udp2srio_segmenter #(
        .DATA_W(DATA_W), .SEG_BYTES(SEG), .ADDR_W(AW),
        .BASE_ADDR(BASE), .ADDR_SPAN(SPAN)
    ) dut (
        .clk_srio(clk_srio), .reset_srio(reset_srio),
        .udp_data_in(udp_data_in), .udp_valid_in(udp_valid_in),
        .udp_first_in(udp_first_in), .udp_keep_in(udp_keep_in),
        .udp_last_in(udp_last_in), .udp_length_in(udp_length_in),
        .udp_ready_out(udp_ready_out), .nwr_req_out(nwr_req_out),
        .nwr_ack_in(nwr_ack_in), .srio_addr_out(srio_addr_out),
        .srio_length_out(srio_length_out), .srio_data_out(srio_data_out),
        .srio_valid_out(srio_valid_out), .srio_first_out(srio_first_out),
        .srio_keep_out(srio_keep_out), .srio_last_out(srio_last_out),
        .srio_ready_in(srio_ready_in), .err_clr_in(err_clr_in),
`ifdef UDP2SRIO_STATS_EN
        .stat_frames_out(stat_frames_out), .stat_segs_out(stat_segs_out),
        .stat_errs_out(stat_errs_out),
`endif
        .err_out(err_out)
    );

    always #5 clk_srio = ~clk_srio;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } req_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        first;
        logic        last;
    } beat_t;

    req_t        req_q[$];
    beat_t       beat_q[$];
    logic [63:0] fdata[$];
    logic [7:0]  fkeep[$];
    int unsigned m_off = 0;
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b1;
    bit          rand_en = 1'b1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Segment-level model: declared length L, nb beats actually sent.
    function automatic bit plan(input int L, input int nb);
        int rem, seg, sb, avail, take, bi;
        bit err;
        bi = 0;
        err = 1'b0;
        if (L == 0) return 1'b1;
        rem = L;
        forever begin
            seg = (rem > SEG) ? SEG : rem;
            req_q.push_back('{addr: BASE + AW'(m_off), len: 8'(seg - 1)});
            sb = (seg + KEEP_W - 1) / KEEP_W;
            avail = nb - bi;
            take = (avail <= sb) ? avail : sb;
            for (int k = 0; k < take; k++)
                beat_q.push_back('{data: fdata[bi+k], keep: fkeep[bi+k],
                                   first: (k == 0), last: (k == take - 1)});
            bi += take;
            rem -= seg;
            m_off = (m_off + sb * KEEP_W) % SPAN;
            if (avail <= sb) begin
                err = (avail < sb) || (rem != 0);
                break;
            end
            if (rem == 0) begin
                err = 1'b1;
                break;
            end
        end
        return err;
    endfunction

    task automatic send_frame(input int L, input int N, input bit clr_first);
        int nb, rb, n;
        bit got, exp_err;
        logic [8:0] t;
        nb = (N + KEEP_W - 1) / KEEP_W;
        fdata.delete();
        fkeep.delete();
        for (int i = 0; i < nb; i++) begin
            fdata.push_back({$urandom, $urandom});
            fkeep.push_back(8'hFF);
        end
        rb = N - KEEP_W * (nb - 1);
        t = (9'd1 << rb) - 9'd1;
        fkeep[nb-1] = t[7:0];
        exp_err = plan(L, nb);
        for (int i = 0; i < nb; i++) begin
            if (i > 0 && ($urandom % 4) == 0) begin
                udp_valid_in = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk_srio);
                #1;
            end
            udp_valid_in  = 1'b1;
            udp_first_in  = (i == 0);
            udp_last_in   = (i == nb - 1);
            udp_data_in   = fdata[i];
            udp_keep_in   = fkeep[i];
            udp_length_in = (i == 0) ? 16'(L) : 16'd0;
            if (i == 0) err_clr_in = clr_first;
            got = 1'b0;
            n = 0;
            while (!got && n < 200) begin
                @(negedge clk_srio);
                got = udp_ready_out;
                n++;
                if (!got) begin
                    @(posedge clk_srio);
                    #1;
                    err_clr_in = 1'b0;
                end
            end
            if (!got) begin
                checks++;
                errors++;
                $display("FAIL beat_timeout actual=not_accepted required=accepted beat=%0d", i);
            end else begin
                @(posedge clk_srio);
                #1;
                err_clr_in = 1'b0;
            end
        end
        udp_valid_in = 1'b0;
        udp_first_in = 1'b0;
        udp_last_in  = 1'b0;
        chk("err_flag", 64'(err_out), 64'(exp_err));
        chk("req_q_left", 64'(req_q.size()), 64'd0);
        chk("beat_q_left", 64'(beat_q.size()), 64'd0);
        if (err_out) begin
            err_clr_in = 1'b1;
            @(posedge clk_srio);
            #1;
            err_clr_in = 1'b0;
            chk("err_clear", 64'(err_out), 64'd0);
        end
    endtask

    initial begin : drv_rand
        srio_ready_in = 1'b0;
        nwr_ack_in    = 1'b0;
        forever begin
            @(posedge clk_srio);
            #1;
            if (rand_en) begin
                srio_ready_in = ($urandom % 3) != 0;
                nwr_ack_in    = ($urandom % 3) == 0;
            end else begin
                srio_ready_in = 1'b1;
                nwr_ack_in    = 1'b1;
            end
        end
    end

    initial begin : monitor
        req_t  r;
        beat_t b;
        forever begin
            @(negedge clk_srio);
            if (mon_en && nwr_req_out && nwr_ack_in) begin
                if (req_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL req_extra actual=%0h required=none", srio_addr_out);
                end else begin
                    r = req_q.pop_front();
                    chk("req_addr", 64'(srio_addr_out), 64'(r.addr));
                    chk("req_len", 64'(srio_length_out), 64'(r.len));
                end
            end
            if (mon_en && srio_valid_out && srio_ready_in) begin
                if (beat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat_extra actual=%0h required=none", srio_data_out);
                end else begin
                    b = beat_q.pop_front();
                    chk("beat_data", srio_data_out, b.data);
                    chk("beat_keep", 64'(srio_keep_out), 64'(b.keep));
                    chk("beat_first", 64'(srio_first_out), 64'(b.first));
                    chk("beat_last", 64'(srio_last_out), 64'(b.last));
                end
            end
        end
    end

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_req"}, 64'(nwr_req_out), 64'd0);
        chk({tag, "_len"}, 64'(srio_length_out), 64'd0);
        chk({tag, "_valid"}, 64'(srio_valid_out), 64'd0);
        chk({tag, "_first"}, 64'(srio_first_out), 64'd0);
        chk({tag, "_last"}, 64'(srio_last_out), 64'd0);
        chk({tag, "_keep"}, 64'(srio_keep_out), 64'd0);
        chk({tag, "_data"}, srio_data_out, 64'd0);
        chk({tag, "_ready"}, 64'(udp_ready_out), 64'd0);
        chk({tag, "_err"}, 64'(err_out), 64'd0);
        chk({tag, "_addr"}, 64'(srio_addr_out), 64'(BASE));
    endtask

    initial begin : main
        int L, N, mode;
        reset_srio    = 1'b1;
        udp_data_in   = '0;
        udp_valid_in  = 1'b0;
        udp_first_in  = 1'b0;
        udp_keep_in   = '0;
        udp_last_in   = 1'b0;
        udp_length_in = '0;
        err_clr_in    = 1'b0;
        #1;
        chk_idle_outputs("rst");
`ifdef UDP2SRIO_STATS_EN
        chk("rst_frames", 64'(stat_frames_out), 64'd0);
`endif
        repeat (3) @(posedge clk_srio);
        @(negedge clk_srio);
        reset_srio = 1'b0;
        @(posedge clk_srio);
        #1;

        send_frame(64, 64, 1'b0);
        send_frame(600, 600, 1'b0);
`ifdef UDP2SRIO_STATS_EN
        chk("stat_frames", 64'(stat_frames_out), 64'd2);
        chk("stat_segs", 64'(stat_segs_out), 64'd4);
        chk("stat_errs", 64'(stat_errs_out), 64'd0);
`endif
        send_frame(128, 64, 1'b0);
        send_frame(64, 128, 1'b0);
        send_frame(0, 16, 1'b1);
        send_frame(512, 512, 1'b0);
        send_frame(599, 599, 1'b0);

        for (int f = 0; f < 40; f++) begin
            L = $urandom_range(1, 700);
            mode = $urandom % 8;
            if (mode == 0 && L > 1) N = $urandom_range(1, L - 1);
            else if (mode == 1) N = L + $urandom_range(1, 300);
            else N = L;
            send_frame(L, N, 1'b0);
        end

        mon_en  = 1'b0;
        rand_en = 1'b0;
        repeat (2) @(posedge clk_srio);
        #1;
        udp_valid_in  = 1'b1;
        udp_first_in  = 1'b1;
        udp_last_in   = 1'b0;
        udp_length_in = 16'd600;
        udp_keep_in   = 8'hFF;
        udp_data_in   = {$urandom, $urandom};
        repeat (6) @(posedge clk_srio);
        #1;
        chk("mid_seg_valid", 64'(srio_valid_out), 64'd1);
        reset_srio = 1'b1;
        #1;
        chk_idle_outputs("async_rst");
        @(posedge clk_srio);
        #1;
        chk("rst_edge_valid", 64'(srio_valid_out), 64'd0);
        udp_valid_in = 1'b0;
        udp_first_in = 1'b0;
        @(negedge clk_srio);
        reset_srio = 1'b0;
        m_off   = 0;
        mon_en  = 1'b1;
        rand_en = 1'b1;
        @(posedge clk_srio);
        #1;
        send_frame(64, 64, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
